// File: rtl/mux8_scan_capture.sv
// mux8_scan_capture
// Sequential scan controller for an 8:1 dataflow mux stage. It walks the mux
// select lines through channels 0..7. After each channel settles for DWELL
// cycles, it samples the mux output. The eight samples are presented as one
// parallel word on a valid/ready handshake.
//
// Ports:
//   clk      - single clock, rising-edge active
//   rst_n    - asynchronous active-low reset
//   start    - begin a scan (only looked at while idle)
//   cont     - continuous mode, latched when start is accepted
//   y_in     - mux output y
//   sel_s0   - mux select LSB   (registered copy of the channel number)
//   sel_s1   - mux select middle bit
//   sel_s2   - mux select MSB
//   data_out - captured word, bit k = y_in while channel k was selected
//   valid    - data_out holds a complete frame
//   ready    - downstream accepts the frame when valid & ready
//   busy     - high in every state except IDLE
module mux8_scan_capture #(
  parameter int DWELL = 2,
  parameter int CNT_W = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       cont,
  input  logic       y_in,
  output logic       sel_s0,
  output logic       sel_s1,
  output logic       sel_s2,
  output logic [7:0] data_out,
  output logic       valid,
  input  logic       ready,
  output logic       busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  // The settle counter counts down to zero, so loading DWELL-1 gives
  // exactly DWELL cycles in SETTLE.
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DWELL - 1);

  logic [1:0]       r_state;
  logic [2:0]       r_ch;
  logic [CNT_W-1:0] r_cnt;
  // Only channels 0..6 need shadow storage.
  // Channel 7 goes straight into the output word on its sample cycle.
  logic [6:0]       r_shadow;
  logic             r_cont;
  logic [7:0]       r_data;
  logic             r_valid;
  logic             r_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_ch     <= 3'd0;
      r_cnt    <= '0;
      r_shadow <= 7'd0;
      r_cont   <= 1'b0;
      r_data   <= 8'h00;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_SETTLE;
            r_ch    <= 3'd0;
            r_cnt   <= CNT_RELOAD;
            r_cont  <= cont;
            r_busy  <= 1'b1;
          end
        end

        S_SETTLE: begin
          if (r_cnt == '0) begin
            r_state <= S_SAMPLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        S_SAMPLE: begin
          for (int k = 0; k < 7; k++) begin
            if (r_ch == 3'(k)) begin
              r_shadow[k] <= y_in;
            end
          end
          if (r_ch != 3'd7) begin
            r_ch    <= r_ch + 3'd1;
            r_cnt   <= CNT_RELOAD;
            r_state <= S_SETTLE;
          end else begin
            // The last sample bypasses the shadow.
            // The frame therefore completes on this edge.
            r_data  <= {y_in, r_shadow};
            r_valid <= 1'b1;
            r_state <= S_HOLD;
          end
        end

        S_HOLD: begin
          // In HOLD, valid is always 1, so ready alone completes the handshake.
          if (ready) begin
            r_valid <= 1'b0;
            r_ch    <= 3'd0;
            if (r_cont) begin
              r_cnt   <= CNT_RELOAD;
              r_state <= S_SETTLE;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign sel_s0   = r_ch[0];
  assign sel_s1   = r_ch[1];
  assign sel_s2   = r_ch[2];
  assign data_out = r_data;
  assign valid    = r_valid;
  assign busy     = r_busy;

endmodule

// File: tb/tb_mux8_scan_capture.sv
// tb_mux8_scan_capture
// Self-checking bench for mux8_scan_capture.
// Instance A is built with DWELL=2 and instance B with DWELL=1.
// The bench models the 8:1 mux as y = pattern[{s2,s1,s0}].
// Expected values come from the scan rules:
//   - channel n is selected for cycles n*(DWELL+1) .. n*(DWELL+1)+DWELL
//   - valid appears 8*(DWELL+1) edges after the start edge
//   - the captured word equals the mux pattern
module tb_mux8_scan_capture;

  logic clk;
  logic rst_n;

  logic       startA, contA, readyA, yA, s0A, s1A, s2A, validA, busyA;
  logic [7:0] dataA, patA;
  logic       startB, contB, readyB, yB, s0B, s1B, s2B, validB, busyB;
  logic [7:0] dataB, patB;

  int nCompared;
  int nMismatched;

  logic [2:0] selLog [0:63];

  mux8_scan_capture #(.DWELL(2), .CNT_W(4)) dutA (
    .clk(clk), .rst_n(rst_n), .start(startA), .cont(contA), .y_in(yA),
    .sel_s0(s0A), .sel_s1(s1A), .sel_s2(s2A), .data_out(dataA),
    .valid(validA), .ready(readyA), .busy(busyA)
  );

  mux8_scan_capture #(.DWELL(1), .CNT_W(4)) dutB (
    .clk(clk), .rst_n(rst_n), .start(startB), .cont(contB), .y_in(yB),
    .sel_s0(s0B), .sel_s1(s1B), .sel_s2(s2B), .data_out(dataB),
    .valid(validB), .ready(readyB), .busy(busyB)
  );

  assign yA = patA[{s2A, s1A, s0A}];
  assign yB = patB[{s2B, s1B, s0B}];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] selOf(input int which);
    return (which == 0) ? {s2A, s1A, s0A} : {s2B, s1B, s0B};
  endfunction

  function automatic logic [7:0] dataOf(input int which);
    return (which == 0) ? dataA : dataB;
  endfunction

  function automatic logic validOf(input int which);
    return (which == 0) ? validA : validB;
  endfunction

  function automatic logic busyOf(input int which);
    return (which == 0) ? busyA : busyB;
  endfunction

  function automatic int dwellOf(input int which);
    return (which == 0) ? 2 : 1;
  endfunction

  // Counts logged cycles whose select value differs from the channel
  // that should be active at that cycle.
  function automatic int selWalkErrors(input int dwell, input int n);
    int errs;
    errs = 0;
    for (int t = 0; t < n; t++) begin
      if (selLog[t] !== 3'(t / (dwell + 1))) errs++;
    end
    return errs;
  endfunction

  task automatic setStart(input int which, input logic v);
    if (which == 0) startA = v; else startB = v;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Pulses start so that it is seen on the next edge.
  // Returns #1 after that start edge.
  task automatic startScan(input int which, input logic contVal);
    if (which == 0) contA = contVal; else contB = contVal;
    setStart(which, 1'b1);
    step();
    setStart(which, 1'b0);
  endtask

  // Logs the select lines every cycle from the start edge until valid.
  // Returns the number of edges that valid took, or -1 on timeout.
  // injectEdge (if >0) drives start high so it is sampled on that edge.
  task automatic captureScan(input int which, input int injectEdge, output int edges);
    int e;
    e = 0;
    edges = -1;
    selLog[0] = selOf(which);
    setStart(which, (injectEdge == 1));
    for (int k = 0; k < 200; k++) begin
      step();
      e++;
      setStart(which, ((e + 1) == injectEdge));
      if (validOf(which) === 1'b1) begin
        edges = e;
        break;
      end
      if (e < 64) selLog[e] = selOf(which);
    end
    setStart(which, 1'b0);
  endtask

  task automatic test_reset;
    int errs;
    repeat (2) step();
    #2 rst_n = 1'b0;
    #1;
    errs = 0;
    nCompared++;
    if (selOf(0) !== 3'b000 || dataA !== 8'h00 || validA !== 1'b0 || busyA !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL reset_A: sel=%b data=%h valid=%b busy=%b, want 000/00/0/0",
               selOf(0), dataA, validA, busyA);
    end
    nCompared++;
    if (selOf(1) !== 3'b000 || dataB !== 8'h00 || validB !== 1'b0 || busyB !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL reset_B: sel=%b data=%h valid=%b busy=%b, want 000/00/0/0",
               selOf(1), dataB, validB, busyB);
    end
    @(negedge clk) rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_frame;
    int edges;
    patA = 8'hA5; readyA = 1'b1;
    startScan(0, 1'b0);
    captureScan(0, -1, edges);
    nCompared++;
    if (edges !== 24) begin
      nMismatched++;
      $display("[TB] FAIL single_latency: got %0d edges, want 24", edges);
    end
    nCompared++;
    if (selWalkErrors(2, 24) !== 0) begin
      nMismatched++;
      $display("[TB] FAIL single_selwalk: %0d bad cycles, want 0", selWalkErrors(2, 24));
    end
    nCompared++;
    if (dataA !== 8'hA5) begin
      nMismatched++;
      $display("[TB] FAIL single_data: got %h, want a5", dataA);
    end
    step();
    nCompared++;
    if (validA !== 1'b0 || busyA !== 1'b0 || dataA !== 8'hA5 || selOf(0) !== 3'b000) begin
      nMismatched++;
      $display("[TB] FAIL single_after: valid=%b busy=%b data=%h sel=%b, want 0/0/a5/000",
               validA, busyA, dataA, selOf(0));
    end
  endtask

  task automatic test_backpressure;
    int edges;
    patA = 8'hA5; readyA = 1'b0;
    startScan(0, 1'b0);
    captureScan(0, -1, edges);
    nCompared++;
    if (edges !== 24 || dataA !== 8'hA5) begin
      nMismatched++;
      $display("[TB] FAIL bp_frame: edges=%0d data=%h, want 24/a5", edges, dataA);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      nCompared++;
      if (validA !== 1'b1 || dataA !== 8'hA5 || selOf(0) !== 3'b111 || busyA !== 1'b1) begin
        nMismatched++;
        $display("[TB] FAIL bp_hold%0d: valid=%b data=%h sel=%b busy=%b, want 1/a5/111/1",
                 i, validA, dataA, selOf(0), busyA);
      end
    end
    readyA = 1'b1;
    step();
    nCompared++;
    if (validA !== 1'b0 || busyA !== 1'b0 || selOf(0) !== 3'b000) begin
      nMismatched++;
      $display("[TB] FAIL bp_release: valid=%b busy=%b sel=%b, want 0/0/000",
               validA, busyA, selOf(0));
    end
  endtask

  task automatic test_continuous;
    int edges;
    patA = 8'h3C; readyA = 1'b1;
    startScan(0, 1'b1);
    captureScan(0, -1, edges);
    nCompared++;
    if (edges !== 24 || dataA !== 8'h3C) begin
      nMismatched++;
      $display("[TB] FAIL cont_frame1: edges=%0d data=%h, want 24/3c", edges, dataA);
    end
    // Mode input dropped after acceptance must not stop continuous scanning.
    patA = 8'hC3; contA = 1'b0;
    step();
    nCompared++;
    if (selOf(0) !== 3'b000 || validA !== 1'b0 || busyA !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL cont_handshake: sel=%b valid=%b busy=%b, want 000/0/1",
               selOf(0), validA, busyA);
    end
    captureScan(0, -1, edges);
    nCompared++;
    if (edges !== 24 || dataA !== 8'hC3 || selWalkErrors(2, 24) !== 0) begin
      nMismatched++;
      $display("[TB] FAIL cont_frame2: edges=%0d data=%h selerr=%0d, want 24/c3/0",
               edges, dataA, selWalkErrors(2, 24));
    end
    step();
    nCompared++;
    if (busyA !== 1'b1 || selOf(0) !== 3'b000 || validA !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL cont_rescan: busy=%b sel=%b valid=%b, want 1/000/0",
               busyA, selOf(0), validA);
    end
    #2 rst_n = 1'b0;
    #1;
    nCompared++;
    if (busyA !== 1'b0 || validA !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL cont_reset: busy=%b valid=%b, want 0/0", busyA, validA);
    end
    @(negedge clk) rst_n = 1'b1;
    step();
  endtask

  task automatic test_start_ignored_and_abort;
    int edges;
    patA = 8'hA5; readyA = 1'b1;
    startScan(0, 1'b0);
    captureScan(0, 10, edges);
    nCompared++;
    if (edges !== 24 || dataA !== 8'hA5 || selWalkErrors(2, 24) !== 0) begin
      nMismatched++;
      $display("[TB] FAIL ignore_start: edges=%0d data=%h selerr=%0d, want 24/a5/0",
               edges, dataA, selWalkErrors(2, 24));
    end
    step();
    step();
    nCompared++;
    if (busyA !== 1'b0 || validA !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL ignore_idle: busy=%b valid=%b, want 0/0", busyA, validA);
    end
    patA = 8'h5A;
    startScan(0, 1'b0);
    repeat (12) step();
    nCompared++;
    if (selOf(0) !== 3'd4 || busyA !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL abort_pos: sel=%b busy=%b, want 100/1", selOf(0), busyA);
    end
    #2 rst_n = 1'b0;
    #1;
    nCompared++;
    if (selOf(0) !== 3'b000 || dataA !== 8'h00 || validA !== 1'b0 || busyA !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL abort_reset: sel=%b data=%h valid=%b busy=%b, want 000/00/0/0",
               selOf(0), dataA, validA, busyA);
    end
    @(negedge clk) rst_n = 1'b1;
    step();
    patA = 8'hA5;
    startScan(0, 1'b0);
    captureScan(0, -1, edges);
    nCompared++;
    if (edges !== 24 || dataA !== 8'hA5) begin
      nMismatched++;
      $display("[TB] FAIL abort_clean: edges=%0d data=%h, want 24/a5", edges, dataA);
    end
    step();
  endtask

  task automatic test_dwell1;
    int edges;
    logic [7:0] pats [0:1];
    pats[0] = 8'hFF;
    pats[1] = 8'h00;
    readyB = 1'b1;
    for (int i = 0; i < 2; i++) begin
      patB = pats[i];
      startScan(1, 1'b0);
      captureScan(1, -1, edges);
      nCompared++;
      if (edges !== 16 || dataB !== pats[i] || selWalkErrors(1, 16) !== 0) begin
        nMismatched++;
        $display("[TB] FAIL dwell1_frame%0d: edges=%0d data=%h selerr=%0d, want 16/%h/0",
                 i, edges, dataB, selWalkErrors(1, 16), pats[i]);
      end
      step();
      nCompared++;
      if (validB !== 1'b0 || busyB !== 1'b0) begin
        nMismatched++;
        $display("[TB] FAIL dwell1_after%0d: valid=%b busy=%b, want 0/0", i, validB, busyB);
      end
    end
  endtask

  task automatic test_random;
    int edges, which, delay, heldBad;
    logic [7:0] pat;
    for (int it = 0; it < 8; it++) begin
      which = int'($urandom_range(0, 1));
      pat   = 8'($urandom);
      delay = int'($urandom_range(0, 4));
      if (which == 0) begin patA = pat; readyA = (delay == 0); end
      else            begin patB = pat; readyB = (delay == 0); end
      startScan(which, 1'b0);
      captureScan(which, -1, edges);
      nCompared++;
      if (edges !== 8 * (dwellOf(which) + 1) || dataOf(which) !== pat) begin
        nMismatched++;
        $display("[TB] FAIL rand%0d_frame: dut=%0d edges=%0d data=%h, want %0d/%h",
                 it, which, edges, dataOf(which), 8 * (dwellOf(which) + 1), pat);
      end
      heldBad = 0;
      for (int d = 0; d < delay; d++) begin
        step();
        if (validOf(which) !== 1'b1 || dataOf(which) !== pat) heldBad++;
      end
      if (which == 0) readyA = 1'b1; else readyB = 1'b1;
      step();
      nCompared++;
      if (heldBad !== 0 || validOf(which) !== 1'b0 || busyOf(which) !== 1'b0) begin
        nMismatched++;
        $display("[TB] FAIL rand%0d_release: held_bad=%0d valid=%b busy=%b, want 0/0/0",
                 it, heldBad, validOf(which), busyOf(which));
      end
    end
  endtask

  initial begin
    nCompared = 0;
    nMismatched = 0;
    rst_n = 1'b1;
    startA = 1'b0; contA = 1'b0; readyA = 1'b1; patA = 8'h00;
    startB = 1'b0; contB = 1'b0; readyB = 1'b1; patB = 8'h00;

    test_reset();
    test_single_frame();
    test_backpressure();
    test_continuous();
    test_start_ignored_and_abort();
    test_dwell1();
    test_random();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
